// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
//   Shared definitions for the baud-rate change sequencer.
//   - BC select codes understood by the UART baud generator (BC_MAX is the
//     highest legal code; anything above it is rejected).
//   - State encoding of the change-sequencing FSM, exported on the debug port.
// ---------------------------------------------------------------------------
package baud_pkg;

  localparam logic [2:0] BC_9600   = 3'd0;
  localparam logic [2:0] BC_19200  = 3'd1;
  localparam logic [2:0] BC_38400  = 3'd2;
  localparam logic [2:0] BC_57600  = 3'd3;
  localparam logic [2:0] BC_115200 = 3'd4;
  localparam logic [2:0] BC_MAX    = BC_115200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_APPLY  = 3'd3,
    ST_SETTLE = 3'd4
  } baud_state_e;

endpackage

// File: rtl/baud_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// baud_cfg_ctrl
//   Sequences a run-time baud-rate change: accepts a request, checks it,
//   holds the TX/RX framers off new frames until the link is idle, drives the
//   new BC code to the baud generator and waits for its tick to settle.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high. req_ready is high only while the FSM is idle;
//   req_valid with req_ready low is ignored (nothing is queued).
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   req_valid  in   change request valid
//   req_bc     in   requested BC code (3 bits)
//   req_ready  out  high only in IDLE
//   tx_busy    in   transmitter mid-frame
//   rx_busy    in   receiver mid-frame
//   baud_tick  in   1-cycle tick from the baud generator
//   hold       out  framers must not start new frames while high
//   bc_out     out  registered BC select to the baud generator
//   done       out  1-cycle pulse: request completed (also same-code no-op)
//   err        out  1-cycle pulse: request rejected or aborted
//   dbg_state  out  current FSM state (baud_state_e encoding)
//
// Configuration macro
//   BAUD_TIMEOUT_EN  when defined, DRAIN aborts with err after TIMEOUT_CYC
//                    clk cycles of a busy link; otherwise DRAIN waits forever.
// ---------------------------------------------------------------------------
module baud_cfg_ctrl
  import baud_pkg::*;
#(
  parameter logic [2:0] RESET_BC     = BC_9600,
  parameter int         SETTLE_TICKS = 2,
  parameter int         TIMEOUT_CYC  = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_bc,
  output logic       req_ready,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       baud_tick,
  output logic       hold,
  output logic [2:0] bc_out,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Elaboration-time guard on the parameter ranges.
  if (SETTLE_TICKS < 1 || SETTLE_TICKS > 15 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("baud_cfg_ctrl: SETTLE_TICKS must be 1..15 and TIMEOUT_CYC >= 2");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_TICKS - 1);

`ifdef BAUD_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] drain_cnt;
`endif

  baud_state_e state;
  logic [2:0]  pend_bc;
  logic [3:0]  settle_cnt;
  logic        link_busy;

  assign link_busy = tx_busy | rx_busy;
  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend_bc    <= RESET_BC;
      settle_cnt <= 4'd0;
      hold       <= 1'b0;
      bc_out     <= RESET_BC;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef BAUD_TIMEOUT_EN
      drain_cnt  <= '0;
`endif
    end else begin
      // done/err are single-cycle pulses unless re-armed below.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            pend_bc <= req_bc;
            state   <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (pend_bc > BC_MAX) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else if (pend_bc == bc_out) begin
            // Nothing to change: complete without disturbing the framers.
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            hold  <= 1'b1;
            state <= ST_DRAIN;
`ifdef BAUD_TIMEOUT_EN
            drain_cnt <= '0;
`endif
          end
        end

        ST_DRAIN: begin
          // A frame that started as hold rose is still reported busy here,
          // so it is allowed to finish before the code changes.
          if (!link_busy) begin
            bc_out     <= pend_bc;
            settle_cnt <= 4'd0;
            state      <= ST_APPLY;
          end
`ifdef BAUD_TIMEOUT_EN
          else if (drain_cnt == TO_LAST) begin
            err   <= 1'b1;
            hold  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
`endif
        end

        ST_APPLY: begin
          // The new code is on bc_out this cycle; a tick seen now still
          // belongs to the old rate and is not counted.
          settle_cnt <= 4'd0;
          state      <= ST_SETTLE;
        end

        ST_SETTLE: begin
          // No clk timeout: the generator may wrap its stale counter and
          // take up to 512 clk to produce the first tick at the new rate.
          if (baud_tick) begin
            if (settle_cnt == SETTLE_LAST) begin
              done  <= 1'b1;
              hold  <= 1'b0;
              state <= ST_IDLE;
            end else if (settle_cnt != 4'hF) begin
              settle_cnt <= settle_cnt + 4'd1;
            end
          end
        end

        default: begin
          hold  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_baud_cfg_ctrl
//   Bench for baud_cfg_ctrl. A sequential reference thread follows each
//   request transaction from accept to completion and publishes the outputs
//   the DUT must show; a negedge compare process checks them every cycle.
//   Directed tests pin the reference with hand-computed values, then a
//   randomized phase drives requests, link activity, ticks and resets.
// ---------------------------------------------------------------------------
module tb_baud_cfg_ctrl;
  import baud_pkg::*;

  localparam logic [2:0] RESET_BC     = 3'd0;
  localparam int         SETTLE_TICKS = 2;
  localparam int         TIMEOUT_CYC  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       req_valid, tx_busy, rx_busy, baud_tick;
  logic [2:0] req_bc;
  logic       req_ready, hold, done, err;
  logic [2:0] bc_out, dbg_state;

  baud_cfg_ctrl #(
    .RESET_BC    (RESET_BC),
    .SETTLE_TICKS(SETTLE_TICKS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_bc   (req_bc),
    .req_ready(req_ready),
    .tx_busy  (tx_busy),
    .rx_busy  (rx_busy),
    .baud_tick(baud_tick),
    .hold     (hold),
    .bc_out   (bc_out),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic [3:0] exp_q[$];   // {is_err, bc_out} for every predicted completion

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] m_bc;
  logic       m_hold, m_done, m_err, m_ready;

  task automatic model_reset();
    m_bc = RESET_BC; m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ready = 1'b1;
  endtask

  // One pass of the outer loop = one request transaction. Every wait point
  // is a clock edge; a reset seen on any edge abandons the transaction.
  initial begin : model
    logic [2:0] pbc;
    int n, ticks, outcome;
    model_reset();
    forever begin
      @(posedge clk);
      m_done = 1'b0; m_err = 1'b0;
      if (rst) begin model_reset(); continue; end
      if (!(req_valid && m_ready)) continue;
      pbc = req_bc; m_ready = 1'b0;

      @(posedge clk);                     // request is examined
      if (rst) begin model_reset(); continue; end
      if (pbc > 3'd4) begin
        m_err = 1'b1; m_ready = 1'b1; exp_q.push_back({1'b1, m_bc}); continue;
      end
      if (pbc == m_bc) begin
        m_done = 1'b1; m_ready = 1'b1; exp_q.push_back({1'b0, m_bc}); continue;
      end
      m_hold = 1'b1;

      // Wait for an idle link: outcome 0 = drained, 1 = reset, 2 = timed out.
      n = 0; outcome = 0;
      forever begin
        @(posedge clk);
        if (rst) begin outcome = 1; break; end
        if (!tx_busy && !rx_busy) break;
`ifdef BAUD_TIMEOUT_EN
        if (n == TIMEOUT_CYC - 1) begin
          m_err = 1'b1; m_hold = 1'b0; m_ready = 1'b1;
          exp_q.push_back({1'b1, m_bc});
          outcome = 2; break;
        end
`endif
        n++;
      end
      if (outcome == 1) begin model_reset(); continue; end
      if (outcome == 2) continue;
      m_bc = pbc;

      @(posedge clk);                     // tick here belongs to the old rate
      if (rst) begin model_reset(); continue; end

      ticks = 0; outcome = 0;
      forever begin
        @(posedge clk);
        if (rst) begin outcome = 1; break; end
        if (baud_tick) ticks++;
        if (ticks == SETTLE_TICKS) begin
          m_done = 1'b1; m_hold = 1'b0; m_ready = 1'b1;
          exp_q.push_back({1'b0, m_bc});
          break;
        end
      end
      if (outcome == 1) model_reset();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check3("bc_out", bc_out, m_bc);
      check1("hold", hold, m_hold);
      check1("done", done, m_done);
      check1("err", err, m_err);
      check1("req_ready", req_ready, m_ready);
      check1("done_err_excl", done & err, 1'b0);
      if (done | err) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL completion: got done=%b err=%b expected none at %0t", done, err, $time);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check1("completion_kind", err, e[3]);
          check3("completion_bc", bc_out, e[2:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_bc = 3'd0; tx_busy = 1'b0; rx_busy = 1'b0; baud_tick = 1'b0;
  endtask

  // Presents a request for one cycle (caller ensures the DUT is idle).
  task automatic send_req(input logic [2:0] bc);
    req_valid = 1'b1; req_bc = bc;
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic tick_pulses(input int n);
    repeat (n) begin
      baud_tick = 1'b1; cyc(1);
      baud_tick = 1'b0; cyc(2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;

    // T1 reset values
    check3("t1_bc_out", bc_out, 3'd0);
    check1("t1_hold", hold, 1'b0);
    check1("t1_req_ready", req_ready, 1'b1);
    check1("t1_done", done, 1'b0);
    check1("t1_err", err, 1'b0);
    chk_en = 1'b1;

    // T2 idle link, 000 -> 100
    send_req(3'd4);                       // now in the check cycle
    check3("t2_bc_check", bc_out, 3'd0);
    cyc(1);
    check1("t2_hold_drain", hold, 1'b1);
    check3("t2_bc_drain", bc_out, 3'd0);
    cyc(1);
    check3("t2_bc_apply", bc_out, 3'd4);
    baud_tick = 1'b1; cyc(1);             // tick during apply: not counted
    baud_tick = 1'b0; cyc(2);
    baud_tick = 1'b1; cyc(1);             // first counted tick
    baud_tick = 1'b0;
    check1("t2_hold_settle", hold, 1'b1);
    check1("t2_no_done_yet", done, 1'b0);
    cyc(2);
    baud_tick = 1'b1; cyc(1);             // second counted tick
    baud_tick = 1'b0;
    check1("t2_done", done, 1'b1);
    check1("t2_hold_drop", hold, 1'b0);
    cyc(1);
    check1("t2_done_pulse", done, 1'b0);

    // T3 busy link, 100 -> 001
    tx_busy = 1'b1;
    send_req(3'd1);
    cyc(39);
    check1("t3_hold_busy", hold, 1'b1);
    check3("t3_bc_held", bc_out, 3'd4);
    tx_busy = 1'b0;
    cyc(1);
    check3("t3_bc_apply", bc_out, 3'd1);
    tick_pulses(3);
    cyc(2);

    // T4 same code and invalid code
    send_req(3'd3);
    cyc(2);
    tick_pulses(3);
    cyc(2);
    check3("t4_bc_setup", bc_out, 3'd3);
    send_req(3'd3);
    check1("t4_same_hold", hold, 1'b0);
    cyc(1);
    check1("t4_same_done", done, 1'b1);
    check1("t4_same_hold2", hold, 1'b0);
    cyc(1);
    send_req(3'd6);
    cyc(1);
    check1("t4_inv_err", err, 1'b1);
    check3("t4_inv_bc", bc_out, 3'd3);
    cyc(1);

    // T5 reset mid-settle after one counted tick
    send_req(3'd1);
    cyc(2);
    check3("t5_bc_apply", bc_out, 3'd1);
    tick_pulses(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check1("t5_hold", hold, 1'b0);
    check3("t5_bc_reset", bc_out, RESET_BC);
    check1("t5_ready", req_ready, 1'b1);
    check1("t5_no_done", done, 1'b0);
    cyc(1);
    check1("t5_no_done2", done, 1'b0);

`ifdef BAUD_TIMEOUT_EN
    // T6 drain timeout with rx stuck busy
    rx_busy = 1'b1;
    send_req(3'd2);
    cyc(64);
    check1("t6_no_err_yet", err, 1'b0);
    check1("t6_hold_busy", hold, 1'b1);
    cyc(1);
    check1("t6_err", err, 1'b1);
    check1("t6_hold_drop", hold, 1'b0);
    check3("t6_bc_kept", bc_out, RESET_BC);
    rx_busy = 1'b0;
    cyc(2);
`endif

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) tx_busy = ~tx_busy;
      if ($urandom_range(0, 29) == 0) rx_busy = ~rx_busy;
      baud_tick = ($urandom_range(0, 5) == 0);
      req_valid = ($urandom_range(0, 3) == 0);
      req_bc    = 3'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      baud_tick = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    baud_tick = 1'b0;
    cyc(2);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_q_drained: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
